// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute/writeback sequencer for the
// 16-bit core. It fetches over a req/ready handshake, drives the register-file
// selects, computes results with an internal ALU, and writes them back with a
// one-cycle write enable. All outputs come straight from registers.
module control_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic        rf_we,
    output logic [3:0]  rf_sel_in,
    output logic [3:0]  rf_sel_o1,
    output logic [3:0]  rf_sel_o2,
    output logic [15:0] rf_in,
    input  logic [15:0] rf_o1,
    input  logic [15:0] rf_o2,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_LI   = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [15:0] res_q;
    logic [3:0]  rf_sel_in_q;
    logic        rf_we_q;
    logic        imem_req_q;
    logic        halted_q;

    logic [3:0]  op;
    logic [3:0]  rd;
    logic        writes_rf;
    logic [15:0] alu_d;
    logic [15:0] jz_target_d;

    assign op        = ir_q[15:12];
    assign rd        = ir_q[11:8];
    assign writes_rf = (op <= OP_LI);

    // Branch target: off8 = {rd, rs2}, sign-extended, relative to the
    // already-incremented pc; the 16-bit sum wraps naturally.
    assign jz_target_d = pc_q + {{8{ir_q[11]}}, ir_q[11:8], ir_q[3:0]};

    // ALU: operands arrive from the register file on the selects held since DECODE
    always_comb begin
        // NOTE: a default assignment first means every path drives alu_d, so no latch is inferred.
        alu_d = 16'h0000;
        case (op)
            OP_ADD:  alu_d = rf_o1 + rf_o2;
            OP_SUB:  alu_d = rf_o1 - rf_o2;
            OP_AND:  alu_d = rf_o1 & rf_o2;
            OP_OR:   alu_d = rf_o1 | rf_o2;
            OP_XOR:  alu_d = rf_o1 ^ rf_o2;
            OP_SHL:  alu_d = rf_o1 << rf_o2[3:0];
            OP_SHR:  alu_d = rf_o1 >> rf_o2[3:0];
            OP_LI:   alu_d = {8'h00, ir_q[7:0]};
            default: alu_d = 16'h0000;
        endcase
    end

    // Sequencer FSM with registered outputs; reset aborts any cycle, including a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= 16'h0000;
            res_q       <= 16'h0000;
            rf_sel_in_q <= 4'h0;
            rf_we_q     <= 1'b0;
            imem_req_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state_q)
                S_IDLE: begin
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_q       <= imem_data;
                        pc_q       <= pc_q + 16'd1;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (writes_rf) begin
                        // Result and select are registered together so they are
                        // stable for the whole cycle rf_we is high.
                        res_q       <= alu_d;
                        rf_sel_in_q <= rd;
                        rf_we_q     <= 1'b1;
                        state_q     <= S_WRITEBACK;
                    end else if (op == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        if ((op == OP_JZ) && (rf_o1 == 16'h0000)) begin
                            pc_q <= jz_target_d;
                        end
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_WRITEBACK: begin
                    rf_we_q    <= 1'b0;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    rf_we_q    <= 1'b0;
                    imem_req_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign rf_we     = rf_we_q;
    assign rf_sel_in = rf_sel_in_q;
    assign rf_in     = res_q;
    assign rf_sel_o1 = ir_q[7:4];
    assign rf_sel_o2 = ir_q[3:0];
    assign halted    = halted_q;

endmodule
